// File: rtl/ddr3_app_pkg.sv
// Shared state encoding, controller command codes and default widths
// for the DDR3 app-interface master.
package ddr3_app_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RWAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/ddr3_app_wdog.sv
// Read-wait watchdog: counts enabled cycles after a clear, flags LIMIT-1.
// Latency: expired is registered-count compare, same cycle as the count.
// Backpressure: none; holds at the limit until cleared.
module ddr3_app_wdog
  import ddr3_app_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr3_app_master.sv
// Single-beat DDR3 app master, gated on calibration; optional read timeout via DDR_APP_TIMEOUT_EN.
// Latency: cmd_en one cycle after accept; write response at accept+3 with readies high.
// Backpressure: cmd_en / wr_data_en hold with stable payload until ready; rsp_valid is not stallable.
module ddr3_app_master
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [2:0]          cmd,
  output logic                cmd_en,
  output logic [ADDR_W-1:0]   addr,
  input  logic                cmd_ready,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_data_en,
  output logic                wr_data_end,
  output logic [DATA_W/8-1:0] wr_data_mask,
  input  logic                wr_data_rdy,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_data_valid,
  input  logic                rd_data_end,
  output logic [5:0]          app_burst_number,
  output logic                sr_req,
  output logic                ref_req,
  output logic                burst,
  input  logic                init_calib_complete
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                is_wr;
  logic                accept;
  logic                rd_timeout;

  assign is_wr  = (cmd_q == CMD_WR);
  assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef DDR_APP_TIMEOUT_EN
  logic wdog_clr;
  logic wdog_en;

  assign wdog_clr = (state_q == ST_CMD) && cmd_ready && !is_wr;
  assign wdog_en  = (state_q == ST_RWAIT);

  ddr3_app_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (rd_timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));
  assign rd_timeout     = 1'b0;
`endif

  // Only the first beat matters and the low address bits are always zeroed.
  logic unused_ok;
  assign unused_ok = ^{rd_data_end, req_addr[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (init_calib_complete) state_d = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_CMD;
        end else if (!init_calib_complete) begin
          state_d = ST_INIT;
        end
      end
      ST_CMD:   if (cmd_ready) state_d = is_wr ? ST_WDATA : ST_RWAIT;
      ST_WDATA: if (wr_data_rdy) state_d = ST_RESP;
      ST_RWAIT: if (rd_data_valid || rd_timeout) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    cmd_en      = 1'b0;
    wr_data_en  = 1'b0;
    wr_data_end = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_CMD:   cmd_en = 1'b1;
      ST_WDATA: begin
        wr_data_en  = 1'b1;
        wr_data_end = 1'b1;
      end
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cmd_d   = req_we ? CMD_WR : CMD_RD;
      addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
      wdata_d = req_wdata;
      mask_d  = ~req_wstrb;
      err_d   = 1'b0;
    end
    // Real data wins over a timeout landing in the same cycle.
    if (state_q == ST_RWAIT) begin
      if (rd_data_valid) begin
        rdata_d = rd_data;
        err_d   = 1'b0;
      end else if (rd_timeout) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd          = cmd_q;
  assign addr         = addr_q;
  assign wr_data      = wdata_q;
  assign wr_data_mask = mask_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;

  assign app_burst_number = 6'd0;
  assign sr_req           = 1'b0;
  assign ref_req          = 1'b0;
  assign burst            = 1'b0;

endmodule

// File: tb/tb_ddr3_app_master.sv
// Directed bench for ddr3_app_master with a transaction-level reference model.
module tb_ddr3_app_master;

`ifdef DDR_APP_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [27:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0]  req_wstrb = '0;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic         rsp_err;
  logic [2:0]   cmd;
  logic         cmd_en;
  logic [27:0]  addr;
  logic         cmd_ready = 1'b0;
  logic [127:0] wr_data;
  logic         wr_data_en;
  logic         wr_data_end;
  logic [15:0]  wr_data_mask;
  logic         wr_data_rdy = 1'b0;
  logic [127:0] rd_data = '0;
  logic         rd_data_valid = 1'b0;
  logic         rd_data_end = 1'b0;
  logic [5:0]   app_burst_number;
  logic         sr_req;
  logic         ref_req;
  logic         burst;
  logic         init_calib_complete = 1'b0;

  always #5 clk = ~clk;

  ddr3_app_master #(
    .ADDR_W  (28),
    .DATA_W  (128),
    .TIMEOUT (TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_wstrb           (req_wstrb),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_err             (rsp_err),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .cmd_ready           (cmd_ready),
    .wr_data             (wr_data),
    .wr_data_en          (wr_data_en),
    .wr_data_end         (wr_data_end),
    .wr_data_mask        (wr_data_mask),
    .wr_data_rdy         (wr_data_rdy),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .rd_data_end         (rd_data_end),
    .app_burst_number    (app_burst_number),
    .sr_req              (sr_req),
    .ref_req             (ref_req),
    .burst               (burst),
    .init_calib_complete (init_calib_complete)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks which handshake the outstanding transaction still owes.
  logic         m_need_cmd = 1'b0, m_need_wr = 1'b0, m_need_rd = 1'b0, m_rsp_due = 1'b0;
  logic         m_rsp_chk_data = 1'b0, m_exp_err = 1'b0, m_busy;
  logic [127:0] m_exp_rdata = '0;
  logic         m_we = 1'b0;
  logic [27:0]  m_addr = '0;
  logic [127:0] m_wdata = '0;
  logic [15:0]  m_mask = '0;
  int           m_rd_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_need_cmd = 1'b0;
      m_need_wr  = 1'b0;
      m_need_rd  = 1'b0;
      m_rsp_due  = 1'b0;
    end else begin
      m_busy = m_need_cmd | m_need_wr | m_need_rd | m_rsp_due;
      chk("mdl_cmd_en", cmd_en, m_need_cmd);
      chk("mdl_wr_data_en", wr_data_en, m_need_wr);
      chk("mdl_wr_data_end", wr_data_end, m_need_wr);
      chk("mdl_rsp_valid", rsp_valid, m_rsp_due);
      chk("mdl_tieoffs", {app_burst_number, sr_req, ref_req, burst}, 9'd0);
      if (m_busy) chk("mdl_req_ready_busy", req_ready, 1'b0);
      if (m_need_cmd) begin
        chk("mdl_cmd", cmd, m_we ? 3'b000 : 3'b001);
        chk("mdl_addr", addr, m_addr);
      end
      if (m_need_wr) begin
        chk("mdl_wr_data", wr_data, m_wdata);
        chk("mdl_wr_mask", wr_data_mask, m_mask);
      end
      if (m_rsp_due) begin
        chk("mdl_rsp_err", rsp_err, m_exp_err);
        if (m_rsp_chk_data) chk("mdl_rsp_rdata", rsp_rdata, m_exp_rdata);
      end
      // Advance the outstanding transaction, latest phase first.
      m_rsp_due = 1'b0;
      if (m_need_rd) begin
        if (rd_data_valid) begin
          m_need_rd      = 1'b0;
          m_rsp_due      = 1'b1;
          m_rsp_chk_data = 1'b1;
          m_exp_rdata    = rd_data;
          m_exp_err      = 1'b0;
        end else begin
          m_rd_cnt++;
`ifdef DDR_APP_TIMEOUT_EN
          if (m_rd_cnt == TO) begin
            m_need_rd      = 1'b0;
            m_rsp_due      = 1'b1;
            m_rsp_chk_data = 1'b1;
            m_exp_rdata    = '0;
            m_exp_err      = 1'b1;
          end
`endif
        end
      end
      if (m_need_wr && wr_data_rdy) begin
        m_need_wr      = 1'b0;
        m_rsp_due      = 1'b1;
        m_rsp_chk_data = 1'b0;
        m_exp_err      = 1'b0;
      end
      if (m_need_cmd && cmd_ready) begin
        m_need_cmd = 1'b0;
        if (m_we) begin
          m_need_wr = 1'b1;
        end else begin
          m_need_rd = 1'b1;
          m_rd_cnt  = 0;
        end
      end
      if (req_valid && req_ready) begin
        m_need_cmd = 1'b1;
        m_we       = req_we;
        m_addr     = {req_addr[27:3], 3'b000};
        m_wdata    = req_wdata;
        m_mask     = ~req_wstrb;
      end
    end
  end

  task automatic issue(input logic we, input logic [27:0] a, input logic [127:0] d,
                       input logic [15:0] s);
    int n = 0;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("issue_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 128'd0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_cmd_en"}, cmd_en, 1'b0);
    chk({tag, "_cmd"}, cmd, 3'd0);
    chk({tag, "_addr"}, addr, 28'd0);
    chk({tag, "_wr_en_end"}, {wr_data_en, wr_data_end}, 2'b00);
    chk({tag, "_wr_data"}, wr_data, 128'd0);
    chk({tag, "_wr_mask"}, wr_data_mask, 16'd0);
  endtask

  localparam logic [127:0] WDATA0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] RDATA0 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] WDATA1 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

  initial begin
    int waited;
    int rsp_cnt;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Calibration gating with a write pending.
    req_we    = 1'b1;
    req_addr  = 28'h000_0107;
    req_wdata = WDATA0;
    req_wstrb = 16'h00FF;
    req_valid = 1'b1;
    cmd_ready   = 1'b1;
    wr_data_rdy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("gate_req_ready", req_ready, 1'b0);
      chk("gate_cmd_en", cmd_en, 1'b0);
    end
    init_calib_complete = 1'b1;
    waited = 0;
    while (!req_ready && waited < 4) begin
      step();
      waited++;
    end
    chk("gate_release_within_2", (waited <= 2), 1'b1);
    step();
    req_valid = 1'b0;
    chk("wr_cmd_en_t1", cmd_en, 1'b1);
    chk("wr_cmd_t1", cmd, 3'b000);
    chk("wr_addr_t1", addr, 28'h000_0100);
    step();
    chk("wr_data_en_t2", {wr_data_en, wr_data_end}, 2'b11);
    chk("wr_mask_t2", wr_data_mask, 16'hFF00);
    chk("wr_data_t2", wr_data, WDATA0);
    step();
    chk("wr_rsp_t3", rsp_valid, 1'b1);
    chk("wr_rsp_err_t3", rsp_err, 1'b0);
    step();
    chk("wr_rsp_pulse_t4", rsp_valid, 1'b0);
    chk("wr_idle_t4", req_ready, 1'b1);

    // Read with command backpressure then a late data beat.
    cmd_ready = 1'b0;
    issue(1'b0, 28'h0AB_CDEF, 128'd0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk("rd_stall_cmd_en", cmd_en, 1'b1);
      chk("rd_stall_addr", addr, 28'h0AB_CDE8);
      chk("rd_stall_cmd", cmd, 3'b001);
      step();
    end
    cmd_ready = 1'b1;
    chk("rd_cmd_en_at_ready", cmd_en, 1'b1);
    step();
    cmd_ready = 1'b0;
    repeat (12) step();
    rd_data       = RDATA0;
    rd_data_valid = 1'b1;
    rd_data_end   = 1'b1;
    step();
    rd_data_valid = 1'b0;
    rd_data_end   = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_rdata", rsp_rdata, RDATA0);
    chk("rd_rsp_err", rsp_err, 1'b0);
    step();
    rd_data       = 128'hBAD0_BAD0;
    rd_data_valid = 1'b1;
    step();
    rd_data_valid = 1'b0;
    step();
    chk("stray_rd_no_rsp", rsp_valid, 1'b0);

    // Write with write-data backpressure.
    cmd_ready   = 1'b1;
    wr_data_rdy = 1'b0;
    issue(1'b1, 28'hFFF_FFFA, WDATA1, 16'h0F0F);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("wstall_en_end", {wr_data_en, wr_data_end}, 2'b11);
      chk("wstall_data", wr_data, WDATA1);
      chk("wstall_mask", wr_data_mask, 16'hF0F0);
      step();
    end
    wr_data_rdy = 1'b1;
    step();
    rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsp_cnt++;
      step();
    end
    chk("wstall_single_rsp", rsp_cnt, 1);

    // Reset in the middle of a read wait.
    issue(1'b0, 28'h123_4567, 128'd0, 16'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    rd_data       = RDATA0;
    rd_data_valid = 1'b1;
    step();
    rd_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_rsp", rsp_valid, 1'b0);
      step();
    end

`ifdef DDR_APP_TIMEOUT_EN
    // Read that never returns data.
    issue(1'b0, 28'h000_0040, 128'd0, 16'd0);
    step();
    for (int i = 0; i < 16; i++) begin
      chk("to_no_rsp_yet", rsp_valid, 1'b0);
      step();
    end
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 128'd0);
    step();
    chk("to_back_idle", req_ready, 1'b1);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ddr3_app_master.md
# ddr3_app_master

Single-beat initiator for the DDR3 controller user (app) interface: accepts one 128-bit read or write request at a time from the core-side bus and drives the controller's command, write-data and read-data channels. Sits between the core memory port and `DDR3_Memory_Interface_Top`, running on the controller's `clk_out` domain. It holds off all traffic until calibration completes.

## Interface
- `ADDR_W`, 28: app address width.
- `DATA_W`, 128: app data width; mask width is `DATA_W/8`.
- `TIMEOUT`, 1024: read-wait cycle limit, used only with `DDR_APP_TIMEOUT_EN`.

Ports:
- `clk` in 1: sole clock, connected to the controller `clk_out`.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: app address.
- `req_wdata` in DATA_W: write data.
- `req_wstrb` in DATA_W/8: byte enables, 1 = write the byte.
- `rsp_valid` out 1: one-cycle completion pulse for both reads and writes.
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid`.
- `rsp_err` out 1: read timed out, qualified by `rsp_valid`; constant 0 without the macro.
- `cmd` out 3, `cmd_en` out 1, `addr` out 28, `cmd_ready` in 1: controller command channel.
- `wr_data` out DATA_W, `wr_data_en` out 1, `wr_data_end` out 1, `wr_data_mask` out DATA_W/8, `wr_data_rdy` in 1: controller write channel.
- `rd_data` in DATA_W, `rd_data_valid` in 1, `rd_data_end` in 1: controller read channel.
- `app_burst_number` out 6, `sr_req` out 1, `ref_req` out 1, `burst` out 1: tied to 0.
- `init_calib_complete` in 1.

## Operation
- Command encoding: `CMD_WR` = 3'b000, `CMD_RD` = 3'b001.
- Address rule: `addr = {req_addr[27:3], 3'b000}`. The low bits are forced to 0 because one 128-bit beat equals 8 × 16-bit DQ transfers.
- Mask rule: `wr_data_mask = ~req_wstrb` (controller mask bit 1 = byte not written).
- The request (we, addr, wdata, mask) is captured into registers on acceptance. The controller ports are driven only from these registers.
- State machine:
  - INIT: waits for `init_calib_complete` = 1, then goes to IDLE.
  - IDLE: `req_ready` = 1. On `req_valid`, captures the request and goes to CMD. If `init_calib_complete` = 0 (and no request is accepted), goes to INIT.
  - CMD: `cmd_en` = 1, `cmd`/`addr` held. On `cmd_ready`, goes to WDATA for a write or RWAIT for a read.
  - WDATA: `wr_data_en` = `wr_data_end` = 1 with `wr_data`/`wr_data_mask` held. On `wr_data_rdy`, goes to RESP.
  - RWAIT: on `rd_data_valid` (and `rd_data_end`), captures `rd_data` into `rsp_rdata` and goes to RESP.
  - RESP: `rsp_valid` = 1 for one cycle, then back to IDLE.
- A calibration drop outside IDLE is ignored until the block returns to IDLE.
- `rd_data_valid` outside RWAIT is dropped.
- A read data beat is accepted as complete on `rd_data_valid` alone; `rd_data_end` is not checked.

## Timing
- Reset values: state INIT, `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `cmd_en` = 0, `cmd` = 0, `addr` = 0, `wr_data_en` = 0, `wr_data_end` = 0, `wr_data` = 0, `wr_data_mask` = 0.
- Reset mid-transaction aborts immediately; the controller handshakes in flight are abandoned.
- Acceptance cycle T: `cmd_en` = 1 at T+1.
- Write with `cmd_ready` and `wr_data_rdy` both held high: handshakes at T+1 and T+2, `rsp_valid` at T+3.
- Read: `rsp_valid` occurs one cycle after the `rd_data_valid` cycle.
- `cmd_en` and `wr_data_en` stay asserted, with stable payload, until their ready is sampled high; they never deassert early.
- `rsp_valid` has no backpressure.
- Throughput: at most one outstanding transaction; minimum 4 cycles per write, accept to accept.

## Configuration
- `DDR_APP_TIMEOUT_EN` defined:
  - a counter runs in RWAIT; when it reaches `TIMEOUT`-1 cycles, the block goes to RESP with `rsp_err` = 1 and `rsp_rdata` = 0;
  - the counter clears on entering RWAIT.
- Undefined: RWAIT waits indefinitely, `rsp_err` is tied 0, and no counter logic exists.

## Structure
- Package `ddr3_app_pkg` holds:
  - the state enum (INIT, IDLE, CMD, WDATA, RWAIT, RESP);
  - `CMD_WR` / `CMD_RD`;
  - the default widths.
- Optional sub-module `ddr3_app_wdog` (clear/enable/expired counter), instantiated only under `DDR_APP_TIMEOUT_EN`.

## Test plan
- Calibration gating: `init_calib_complete` = 0 for 50 cycles with `req_valid` = 1 -> `req_ready` = 0 and `cmd_en` = 0 throughout. Raise calibration -> accepted within 2 cycles.
- Write: addr 0x000_0107, wdata 0x0123…CDEF, wstrb 0x00FF, readies tied high -> `cmd` = 000, `addr` = 0x000_0100, `wr_data_mask` = 0xFF00, `rsp_valid` at T+3.
- Read with backpressure: `cmd_ready` low for 5 cycles, then `rd_data_valid` 12 cycles later carrying 0xDEAD…BEEF -> `cmd_en`/`addr` stable while stalled; `rsp_rdata` = 0xDEAD…BEEF with `rsp_err` = 0.
- Write stall: `wr_data_rdy` low for 7 cycles -> `wr_data_en` = `wr_data_end` = 1 and payload stable for all 7 cycles; a single `rsp_valid` follows.
- Reset mid-read (`rst` = 1 during RWAIT) -> next cycle all outputs are at reset values; a late `rd_data_valid` produces no `rsp_valid`.
- With `DDR_APP_TIMEOUT_EN` and `TIMEOUT` = 16: read with no `rd_data_valid` -> `rsp_valid` with `rsp_err` = 1 exactly 16 cycles after entering RWAIT, then IDLE.
